branch_resolve_ctrl: RTL

// Sequences the branch predictor across the pipeline. Records every FETCH prediction in an in-order
// in-flight queue, checks it against the EXEC outcome, and issues a one-cycle redirect on mispredict.

---
 rtl/branch_resolve_ctrl_if.sv | 42 ++++
 rtl/branch_resolve_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl_if.sv
// Bundle of fetch, exec, redirect and predictor-update signals around branch_resolve_ctrl.
// The master side is the pipeline/predictor environment; the slave side is the controller.
interface branch_resolve_ctrl_if #(
    parameter int unsigned IDX_W = 8
) ();
    // Fetch push
    logic             f_valid;
    logic [31:0]      f_pc;
    logic             f_pred_taken;
    logic [31:0]      f_pred_addr;
    logic [IDX_W-1:0] f_index;
    logic             f_ready;
    // Exec resolve
    logic             x_valid;
    logic             x_taken;
    logic [31:0]      x_target;
    logic             x_ready;
    // Redirect and predictor update
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    logic             upd_taken;
    logic             upd_ready;
    // Status
    logic [15:0]      mispredict_cnt;
    logic             underflow_err;

    modport master (
        output f_valid, f_pc, f_pred_taken, f_pred_addr, f_index,
        output x_valid, x_taken, x_target, upd_ready,
        input  f_ready, x_ready, redirect_valid, redirect_pc,
        input  upd_valid, upd_index, upd_taken, mispredict_cnt, underflow_err
    );

    modport slave (
        input  f_valid, f_pc, f_pred_taken, f_pred_addr, f_index,
        input  x_valid, x_taken, x_target, upd_ready,
        output f_ready, x_ready, redirect_valid, redirect_pc,
        output upd_valid, upd_index, upd_taken, mispredict_cnt, underflow_err
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: keeps fetch predictions in an in-order queue, compares the oldest
// against the exec outcome, issues a one-cycle redirect on mispredict and hands the counter
// update to the predictor through a valid/ready handshake.
module branch_resolve_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_resolve_ctrl_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StUpdate = 2'd1;
    localparam logic [1:0] StFlush  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PtrW:0]   cnt_q, cnt_d;

    logic [31:0]      pc_mem    [DEPTH];
    logic             taken_mem [DEPTH];
    logic [31:0]      addr_mem  [DEPTH];
    logic [IDX_W-1:0] idx_mem   [DEPTH];

    logic             mis_q;
    logic             redirect_valid_q;
    logic [31:0]      redirect_pc_q;
    logic [IDX_W-1:0] upd_index_q;
    logic             upd_taken_q;
    logic [15:0]      mis_cnt_q;
    logic             underflow_q;

    logic resolve, underflow_hit, mispredict, push;

    assign bus.f_ready = (cnt_q < Full) && (state_q != StFlush);
    assign bus.x_ready = (state_q == StIdle);

    assign resolve       = bus.x_valid && bus.x_ready && (cnt_q != '0);
    assign underflow_hit = bus.x_valid && bus.x_ready && (cnt_q == '0);
    assign mispredict    = (taken_mem[rd_q] != bus.x_taken) ||
                           (bus.x_taken && (addr_mem[rd_q] != bus.x_target));
    // A fetch arriving alongside a mispredicting resolve is on the wrong path.
    assign push          = bus.f_valid && bus.f_ready && !(resolve && mispredict);

    assign bus.upd_valid      = (state_q == StUpdate);
    assign bus.upd_index      = upd_index_q;
    assign bus.upd_taken      = upd_taken_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.mispredict_cnt = mis_cnt_q;
    assign bus.underflow_err  = underflow_q;

    // Queue pointer/count and FSM next-state.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (push) begin
            wr_d = wr_q + PtrW'(1);
        end
        if (resolve) begin
            rd_d = rd_q + PtrW'(1);
        end
        if (push && !resolve) begin
            cnt_d = cnt_q + (PtrW + 1)'(1);
        end else if (!push && resolve) begin
            cnt_d = cnt_q - (PtrW + 1)'(1);
        end
        case (state_q)
            StIdle: begin
                if (resolve) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                if (bus.upd_ready) begin
                    state_d = mis_q ? StFlush : StIdle;
                end
            end
            StFlush: begin
                // Everything younger than the mispredicted branch is wrong-path.
                rd_d    = wr_q;
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state, update payload, redirect and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            rd_q             <= '0;
            wr_q             <= '0;
            cnt_q            <= '0;
            mis_q            <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            upd_index_q      <= '0;
            upd_taken_q      <= 1'b0;
            mis_cnt_q        <= '0;
            underflow_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            rd_q             <= rd_d;
            wr_q             <= wr_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= resolve && mispredict;
            if (resolve) begin
                upd_index_q <= idx_mem[rd_q];
                upd_taken_q <= bus.x_taken;
                mis_q       <= mispredict;
                if (mispredict) begin
                    redirect_pc_q <= bus.x_taken ? bus.x_target : pc_mem[rd_q] + 32'd4;
                    if (mis_cnt_q != 16'hFFFF) begin
                        mis_cnt_q <= mis_cnt_q + 16'd1;
                    end
                end
            end
            if (underflow_hit) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Record storage; contents are only meaningful between rd and wr, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q]    <= bus.f_pc;
            taken_mem[wr_q] <= bus.f_pred_taken;
            addr_mem[wr_q]  <= bus.f_pred_addr;
            idx_mem[wr_q]   <= bus.f_index;
        end
    end
endmodule
